// File: rtl/sd_stream_loader.sv
// sd_stream_loader: streams a run of consecutive SD blocks into the audio
// sample FIFO. Bytes are packed little-endian into OUT_WIDTH-bit words.
// A block is requested only when the FIFO has room for a whole block.
// The run can optionally loop back to its first block.
module sd_stream_loader #(
    parameter int BLOCK_BYTES = 512,
    parameter int OUT_WIDTH   = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start,
    input  logic                  stop,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [CNT_WIDTH-1:0]  num_blocks,
    input  logic                  loop_en,
    input  logic                  fifo_prog_full,
    input  logic                  sd_ready,
    input  logic                  sd_read_accepted,
    input  logic                  sd_byte_available,
    input  logic [7:0]            sd_dout,
    output logic                  request_sd_read,
    output logic [ADDR_WIDTH-1:0] sd_addr,
    output logic [OUT_WIDTH-1:0]  fifo_din,
    output logic                  fifo_write_enable,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  blocks_done
);

    localparam int BPW = OUT_WIDTH / 8;
    localparam int BCW = $clog2(BLOCK_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ROOM,
        S_REQUEST,
        S_RECEIVE,
        S_NEXT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
    logic [CNT_WIDTH-1:0]  num_blocks_q, num_blocks_d;
    logic                  loop_q, loop_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  blocks_q, blocks_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [OUT_WIDTH-1:0]  pack_q, pack_d;
    logic [OUT_WIDTH-1:0]  fifo_din_q, fifo_din_d;
    logic                  we_q, we_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  hist_q, hist_d;

    logic                  byte_event;
    logic                  word_last;
    logic                  block_last;
    logic [OUT_WIDTH-1:0]  pack_shift;

    // A new byte is a rising edge of the toggle seen against last cycle's value.
    assign byte_event = sd_byte_available & ~hist_q;
    assign block_last = (byte_cnt_q == BCW'(BLOCK_BYTES - 1));

    // Word assembly: a byte-wide FIFO takes every byte directly; wider words
    // shift new bytes in from the top so the first byte ends up in [7:0].
    generate
        if (BPW == 1) begin : g_byte_word
            assign word_last  = 1'b1;
            assign pack_shift = sd_dout;
        end else begin : g_multi_word
            localparam int LW = $clog2(BPW);
            assign word_last  = (byte_cnt_q[LW-1:0] == LW'(BPW - 1));
            assign pack_shift = {sd_dout, pack_q[OUT_WIDTH-1:8]};
        end
    endgenerate

    // Next-state, datapath and registered-output decisions.
    always_comb begin
        state_d      = state_q;
        base_addr_d  = base_addr_q;
        num_blocks_d = num_blocks_q;
        loop_d       = loop_q;
        addr_d       = addr_q;
        blocks_d     = blocks_q;
        byte_cnt_d   = byte_cnt_q;
        pack_d       = pack_q;
        fifo_din_d   = fifo_din_q;
        we_d         = 1'b0;
        req_d        = req_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        stop_pend_d  = stop_pend_q;
        hist_d       = sd_byte_available;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_addr_d  = start_addr;
                    num_blocks_d = num_blocks;
                    loop_d       = loop_en;
                    stop_pend_d  = 1'b0;
                    if (num_blocks == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = S_WAIT_ROOM;
                        busy_d   = 1'b1;
                        addr_d   = start_addr;
                        blocks_d = '0;
                    end
                end
            end
            S_WAIT_ROOM: begin
                if (stop) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (!fifo_prog_full && sd_ready) begin
                    req_d   = 1'b1;
                    state_d = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (sd_read_accepted) begin
                    req_d      = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = S_RECEIVE;
                    if (stop) begin
                        stop_pend_d = 1'b1;
                    end
                end else if (stop) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RECEIVE: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (byte_event) begin
                    pack_d     = pack_shift;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (word_last) begin
                        fifo_din_d = pack_shift;
                        we_d       = 1'b1;
                    end
                    if (block_last) begin
                        blocks_d = blocks_q + CNT_WIDTH'(1);
                        addr_d   = addr_q + ADDR_WIDTH'(BLOCK_BYTES);
                        state_d  = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                // A stop arriving on this very cycle is honoured as well, so no
                // further block is requested after it.
                if (stop_pend_q || stop) begin
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end else if (blocks_q == num_blocks_q) begin
                    if (loop_q) begin
                        addr_d   = base_addr_q;
                        blocks_d = '0;
                        state_d  = S_WAIT_ROOM;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_WAIT_ROOM;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= S_IDLE;
            base_addr_q  <= '0;
            num_blocks_q <= '0;
            loop_q       <= 1'b0;
            addr_q       <= '0;
            blocks_q     <= '0;
            byte_cnt_q   <= '0;
            pack_q       <= '0;
            fifo_din_q   <= '0;
            we_q         <= 1'b0;
            req_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stop_pend_q  <= 1'b0;
            hist_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_addr_q  <= base_addr_d;
            num_blocks_q <= num_blocks_d;
            loop_q       <= loop_d;
            addr_q       <= addr_d;
            blocks_q     <= blocks_d;
            byte_cnt_q   <= byte_cnt_d;
            pack_q       <= pack_d;
            fifo_din_q   <= fifo_din_d;
            we_q         <= we_d;
            req_q        <= req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stop_pend_q  <= stop_pend_d;
            hist_q       <= hist_d;
        end
    end

    assign request_sd_read   = req_q;
    assign sd_addr           = addr_q;
    assign fifo_din          = fifo_din_q;
    assign fifo_write_enable = we_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign blocks_done       = blocks_q;

endmodule

// File: tb/tb_sd_stream_loader.sv
// Testbench for sd_stream_loader: two instances (8-bit and 16-bit FIFO words)
// share one stimulus stream; a byte-queue model predicts every FIFO write.
module tb_sd_stream_loader;

    localparam int BLK = 512;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        start = 1'b0, stop = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] num_blocks = '0;
    logic        loop_en = 1'b0;
    logic        fifo_prog_full = 1'b0;
    logic        sd_ready = 1'b1;
    logic        sd_read_accepted = 1'b0;
    logic        sd_byte_available = 1'b0;
    logic [7:0]  sd_dout = '0;

    logic        req8, we8, busy8, done8;
    logic [31:0] addr8;
    logic [7:0]  din8;
    logic [15:0] bd8;
    logic        req16, we16, busy16, done16;
    logic [31:0] addr16;
    logic [15:0] din16;
    logic [15:0] bd16;

    always #5 clk = ~clk;

    sd_stream_loader #(.BLOCK_BYTES(BLK), .OUT_WIDTH(8)) dut8 (
        .clk_in(clk), .reset_in(reset_in), .start(start), .stop(stop),
        .start_addr(start_addr), .num_blocks(num_blocks), .loop_en(loop_en),
        .fifo_prog_full(fifo_prog_full), .sd_ready(sd_ready),
        .sd_read_accepted(sd_read_accepted), .sd_byte_available(sd_byte_available),
        .sd_dout(sd_dout), .request_sd_read(req8), .sd_addr(addr8),
        .fifo_din(din8), .fifo_write_enable(we8), .busy(busy8), .done(done8),
        .blocks_done(bd8)
    );

    sd_stream_loader #(.BLOCK_BYTES(BLK), .OUT_WIDTH(16)) dut16 (
        .clk_in(clk), .reset_in(reset_in), .start(start), .stop(stop),
        .start_addr(start_addr), .num_blocks(num_blocks), .loop_en(loop_en),
        .fifo_prog_full(fifo_prog_full), .sd_ready(sd_ready),
        .sd_read_accepted(sd_read_accepted), .sd_byte_available(sd_byte_available),
        .sd_dout(sd_dout), .request_sd_read(req16), .sd_addr(addr16),
        .fifo_din(din16), .fifo_write_enable(we16), .busy(busy16), .done(done16),
        .blocks_done(bd16)
    );

    int checks = 0;
    int errors = 0;

    // Model: every byte handed to the loaders must come out of the FIFO port in order.
    logic [7:0]  q8[$];
    logic [7:0]  q16[$];
    int          wr8 = 0, wr16 = 0, req8_cnt = 0, done8_cnt = 0, done16_cnt = 0;
    logic [7:0]  cap8[2];
    logic [15:0] cap16[2];
    logic        prev_we8 = 1'b0, prev_req8 = 1'b0;
    logic [15:0] bd_at_last;
    logic        busy_at_last;
    bit          fix_first = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: checks every FIFO write against the byte model.
    always @(negedge clk) begin
        if (!reset_in) begin
            if (we8) begin
                chk("we8_single_cycle", prev_we8, 0);
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr8_unexpected: got 0x%0h expected no write", din8);
                end else begin
                    chk("fifo_din8", din8, q8.pop_front());
                    if (wr8 < 2) cap8[wr8] = din8;
                    wr8++;
                end
            end
            if (we16) begin
                if (q16.size() < 2) begin
                    checks++;
                    errors++;
                    $display("FAIL wr16_unexpected: got 0x%0h expected no write", din16);
                end else begin
                    logic [7:0] b0, b1;
                    b0 = q16.pop_front();
                    b1 = q16.pop_front();
                    chk("fifo_din16", din16, {b1, b0});
                    if (wr16 < 2) cap16[wr16] = din16;
                    wr16++;
                end
            end
            if (req8 && !prev_req8) req8_cnt++;
            if (done8) done8_cnt++;
            if (done16) done16_cnt++;
            prev_we8  = we8;
            prev_req8 = req8;
        end
    end

    task automatic pulse_start(input logic [31:0] a, input logic [15:0] n, input logic lp);
        @(negedge clk);
        start_addr = a;
        num_blocks = n;
        loop_en    = lp;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (req8) got = 1'b1;
        end
        chk("req_seen", got, 1);
    endtask

    // Serve one SD block. act_kind: 0 none, 1 stop, 2 start, 3 async reset (before byte act_at).
    task automatic serve_block(input logic [31:0] exp_addr, input int act_at, input int act_kind);
        bit got;
        logic [7:0] b;
        logic [7:0] fixed[4];
        fixed[0] = 8'h34; fixed[1] = 8'h12; fixed[2] = 8'h78; fixed[3] = 8'h56;
        wait_req(got);
        if (!got) return;
        chk("req_addr8", addr8, exp_addr);
        chk("req_addr16", addr16, exp_addr);
        chk("req16", req16, 1);
        sd_read_accepted = 1'b1;
        @(negedge clk);
        sd_read_accepted = 1'b0;
        for (int i = 0; i < BLK; i++) begin
            if (act_kind == 3 && i == act_at) begin
                #2 reset_in = 1'b1;
                #1;
                chk("rst_req", {req8, req16}, 0);
                chk("rst_we", {we8, we16}, 0);
                chk("rst_busy", {busy8, busy16}, 0);
                chk("rst_done", {done8, done16}, 0);
                chk("rst_addr", {addr8, addr16}, 0);
                chk("rst_din", {din8, din16}, 0);
                chk("rst_bd", {bd8, bd16}, 0);
                return;
            end
            b = (fix_first && i < 4) ? fixed[i] : 8'($urandom_range(0, 255));
            sd_dout = b;
            sd_byte_available = 1'b1;
            q8.push_back(b);
            q16.push_back(b);
            if (i == act_at && act_kind == 1) stop = 1'b1;
            if (i == act_at && act_kind == 2) begin
                start_addr = 32'h9000;
                num_blocks = 16'd5;
                start      = 1'b1;
            end
            @(negedge clk);
            sd_byte_available = 1'b0;
            stop  = 1'b0;
            start = 1'b0;
            if (i == BLK - 1) begin
                bd_at_last   = bd8;
                busy_at_last = busy8;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int d0, r0, hi;
        bit got;
        // Reset state
        #1;
        chk("reset_req", {req8, req16}, 0);
        chk("reset_busy", {busy8, busy16}, 0);
        chk("reset_addr", {addr8, addr16}, 0);
        chk("reset_din", {din8, din16}, 0);
        chk("reset_misc", {we8, we16, done8, done16, bd8, bd16}, 0);
        repeat (3) @(negedge clk);
        reset_in = 1'b0;

        // Two-block run at 0x1000
        pulse_start(32'h1000, 16'd2, 1'b0);
        chk("t1_busy", busy8, 1);
        chk("t1_addr", addr8, 32'h1000);
        chk("t1_bd", bd8, 0);
        fix_first = 1'b1;
        serve_block(32'h1000, -1, 0);
        fix_first = 1'b0;
        chk("t1_bd_blk1", bd_at_last, 1);
        serve_block(32'h1200, -1, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("t1_writes8", wr8, 1024);
        chk("t1_writes16", wr16, 512);
        chk("t1_requests", req8_cnt, 2);
        chk("t1_done8", done8_cnt, 1);
        chk("t1_done16", done16_cnt, 1);
        chk("t1_bd_final", {bd8, bd16}, {16'd2, 16'd2});
        chk("t1_busy_end", {busy8, busy16}, 0);
        chk("t1_queues", q8.size() + q16.size(), 0);
        chk("lit_byte0", cap8[0], 8'h34);
        chk("lit_byte1", cap8[1], 8'h12);
        chk("lit_word0", cap16[0], 16'h1234);
        chk("lit_word1", cap16[1], 16'h5678);

        // FIFO full holds off the request
        fifo_prog_full = 1'b1;
        pulse_start(32'h3000, 16'd1, 1'b0);
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (req8 || req16) hi++;
        end
        chk("full_no_req", hi, 0);
        fifo_prog_full = 1'b0;
        @(negedge clk);
        chk("full_req_after_drop", {req8, req16}, 2'b11);
        d0 = done8_cnt;
        serve_block(32'h3000, -1, 0);
        repeat (3) @(negedge clk);
        chk("full_done", done8_cnt - d0, 1);

        // Stop at byte 100: block drains, no done, no further request
        d0 = done8_cnt;
        pulse_start(32'h4000, 16'd3, 1'b0);
        r0 = req8_cnt;
        serve_block(32'h4000, 99, 1);
        chk("stop_busy_at_last", busy_at_last, 1);
        chk("stop_busy_after", {busy8, busy16}, 0);
        repeat (20) @(negedge clk);
        #1;
        chk("stop_no_done", done8_cnt - d0, 0);
        chk("stop_no_req", req8_cnt - r0, 1);
        chk("stop_queues", q8.size() + q16.size(), 0);

        // Loop one block at 0x200
        d0 = done8_cnt;
        pulse_start(32'h200, 16'd1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            serve_block(32'h200, -1, 0);
            chk("loop_bd_one", bd_at_last, 1);
            chk("loop_bd_zero", bd8, 0);
            chk("loop_addr_back", addr8, 32'h200);
        end
        wait_req(got);
        chk("loop_req_addr", addr8, 32'h200);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;
        chk("loop_stop_req", {req8, req16}, 0);
        chk("loop_stop_busy", {busy8, busy16}, 0);
        repeat (3) @(negedge clk);
        chk("loop_never_done", done8_cnt - d0, 0);

        // Zero blocks: immediate done, no request
        r0 = req8_cnt;
        d0 = done8_cnt;
        pulse_start(32'h5000, 16'd0, 1'b0);
        chk("zero_done", {done8, done16}, 2'b11);
        chk("zero_busy", busy8, 0);
        @(negedge clk);
        chk("zero_done_pulse", done8, 0);
        repeat (5) @(negedge clk);
        chk("zero_no_req", req8_cnt - r0, 0);

        // Start while busy is ignored
        d0 = done8_cnt;
        pulse_start(32'h8000, 16'd1, 1'b0);
        r0 = req8_cnt;
        serve_block(32'h8000, 50, 2);
        repeat (20) @(negedge clk);
        #1;
        chk("busy_start_done", done8_cnt - d0, 1);
        chk("busy_start_reqs", req8_cnt - r0, 1);
        chk("busy_start_bd", bd8, 1);
        chk("busy_start_addr", addr8, 32'h8200);

        // Asynchronous reset at byte 37
        pulse_start(32'hA000, 16'd1, 1'b0);
        serve_block(32'hA000, 37, 3);
        chk("rst_q8_left", q8.size(), 0);
        chk("rst_q16_left", q16.size(), 1);
        q8.delete();
        q16.delete();
        sd_byte_available = 1'b0;
        repeat (2) @(negedge clk);
        reset_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_after_idle", {busy8, req8, we16}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
